seg7_scan_driver: RTL

- Downstream display stage for the countdown timer. Accepts a 4-digit BCD/code frame over a valid/ready handshake and buffers it in a pending register, then a shadow register.
- Multiplexes the 4 common-anode digits of the board's 7-segment display, with a dead-time gap between digits to suppress ghosting.
- Applies optional leading-zero suppression and per-digit decimal points.
- Replaces the inline case/scan logic currently embedded in the timer.

---
 rtl/seg7_pkg.sv | 64 ++++++
 rtl/seg7_frame_buffer.sv | 57 +++++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: code values, active-low segment patterns,
// the code-to-segment encoder and the leading-zero suppression helper.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Active-low patterns, bit6=a ... bit0=g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Blank zeros from digit3 downward until the first nonzero code; digit0 always kept.
  function automatic logic [15:0] seg7_lz_suppress(input logic [15:0] codes);
    logic [15:0] result;
    logic        zero_run;
    result   = codes;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (zero_run && (codes[i*4 +: 4] == 4'd0)) begin
        result[i*4 +: 4] = CODE_BLANK;
      end else begin
        zero_run = 1'b0;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_frame_buffer.sv
// Two-stage frame store: a pending register filled by the valid/ready input
// and a shadow register that is only updated at the frame boundary.
module seg7_frame_buffer
  import seg7_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lz_en,
  input  logic        i_commit,
  output logic [15:0] o_shadow_codes,
  output logic [3:0]  o_shadow_dp
);

  logic        r_pend_full;
  logic [15:0] r_pend_digits;
  logic [3:0]  r_pend_dp;
  logic        r_pend_lz;
  logic [15:0] r_shadow_codes;
  logic [3:0]  r_shadow_dp;

  logic w_accept;
  logic w_commit;

  // Accept and commit are mutually exclusive: one needs the pending slot empty,
  // the other needs it full, so the new frame can never leak into a commit.
  assign o_ready  = ~r_pend_full;
  assign w_accept = i_valid & ~r_pend_full;
  assign w_commit = i_commit & r_pend_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_full    <= 1'b0;
      r_pend_digits  <= '0;
      r_pend_dp      <= '0;
      r_pend_lz      <= 1'b0;
      r_shadow_codes <= {NUM_DIGITS{CODE_BLANK}};
      r_shadow_dp    <= '0;
    end else if (w_accept) begin
      r_pend_full   <= 1'b1;
      r_pend_digits <= i_digits;
      r_pend_dp     <= i_dp;
      r_pend_lz     <= i_lz_en;
    end else if (w_commit) begin
      r_pend_full    <= 1'b0;
      r_shadow_codes <= r_pend_lz ? seg7_lz_suppress(r_pend_digits) : r_pend_digits;
      r_shadow_dp    <= r_pend_dp;
    end
  end

  assign o_shadow_codes = r_shadow_codes;
  assign o_shadow_dp    = r_shadow_dp;

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: slot counter, DEAD/SHOW scan FSM and
// registered segment/digit outputs fed from the frame buffer's shadow copy.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 9334,
  parameter int DEAD_CYCLES  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  // Handshake: a frame transfers on a rising clock edge where in_valid and
  // in_ready are both 1; while in_ready is 0 the source holds its data.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_digits,
  input  logic [3:0]  in_dp,
  input  logic        in_lz_en,
  output logic        frame_start,
  output logic [6:0]  segmentos,
  output logic        dp_n,
  output logic [3:0]  displays,
  output scan_state_e dbg_state
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  scan_state_e      r_state;
  scan_state_e      w_state_nxt;

  logic             r_frame_start;
  logic [6:0]       r_seg;
  logic             r_dp_n;
  logic [3:0]       r_displays;

  logic [6:0]       w_seg_nxt;
  logic             w_dp_n_nxt;
  logic [3:0]       w_displays_nxt;

  logic             w_wrap;
  logic             w_commit;
  logic [15:0]      w_shadow_codes;
  logic [3:0]       w_shadow_dp;
  logic [3:0]       w_code;

  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_commit = w_wrap && (r_idx == 2'd3);

  seg7_frame_buffer u_frame_buffer (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_valid        (in_valid),
    .o_ready        (in_ready),
    .i_digits       (in_digits),
    .i_dp           (in_dp),
    .i_lz_en        (in_lz_en),
    .i_commit       (w_commit),
    .o_shadow_codes (w_shadow_codes),
    .o_shadow_dp    (w_shadow_dp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_DEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_code = w_shadow_codes[{r_idx, 2'b00} +: 4];

  // The state describes what the output registers will show next cycle.
  always_comb begin
    w_state_nxt    = ST_DEAD;
    w_displays_nxt = 4'b1111;
    w_seg_nxt      = SEG_BLANK;
    w_dp_n_nxt     = 1'b1;
    if (r_cnt >= CNT_DEAD) begin
      w_state_nxt = ST_SHOW;
    end
    case (w_state_nxt)
      ST_SHOW: begin
        w_displays_nxt = ~(4'b0001 << r_idx);
        w_seg_nxt      = seg7_encode(w_code);
        w_dp_n_nxt     = ~w_shadow_dp[r_idx];
      end
      default: begin
        w_displays_nxt = 4'b1111;
        w_seg_nxt      = SEG_BLANK;
        w_dp_n_nxt     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
      r_seg         <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_displays    <= 4'b1111;
    end else begin
      r_frame_start <= (r_cnt == '0) && (r_idx == 2'd0);
      r_seg         <= w_seg_nxt;
      r_dp_n        <= w_dp_n_nxt;
      r_displays    <= w_displays_nxt;
    end
  end

  assign frame_start = r_frame_start;
  assign segmentos   = r_seg;
  assign dp_n        = r_dp_n;
  assign displays    = r_displays;
  assign dbg_state   = r_state;

endmodule
